// File: rtl/branch_resolve.sv
// branch_resolve: IF/ID pipeline register plus decode-stage branch resolution.
// Drives next-PC controls back to fetch, squashes the wrong-path slot after a
// taken branch and holds fetch while a B.cond waits for valid flags.
// Optional feature: define BRANCH_STATS_EN to add br_count / br_taken_count.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// RUN        | normal flow; ID instruction resolves this cycle
// WAIT_FLAGS | B.cond parked in ID until flags_valid rises
// SQUASH     | ID holds the bubble that replaced the wrong-path fetch
module branch_resolve #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [63:0] PCaddr_IF,
    input  logic        stall_in,
    input  logic [3:0]  flags,
    input  logic        flags_valid,
    input  logic        zero_reg,
    output logic [31:0] instr_ID,
    output logic        valid_ID,
    output logic [63:0] PCaddr_Reg,
    output logic [1:0]  BrTaken,
    output logic        UncondBr,
    output logic [18:0] CondAddr19,
    output logic [25:0] BrAddr26,
    output logic        pc_hold
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] br_taken_count
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_FLAGS = 2'd1,
        SQUASH     = 2'd2
    } state_t;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_REL = 2'b01;
    localparam logic [1:0] SEL_REG = 2'b10;

    state_t state, state_next;

    logic is_uncond, is_cbz, is_bcond, is_br;
    logic cond_true;
    logic flag_n, flag_z, flag_c, flag_v;
    logic hold_ifid, squash_ifid, resolved;
    logic [1:0] br_sel;

    assign CondAddr19 = instr_ID[23:5];
    assign BrAddr26   = instr_ID[25:0];
    assign {flag_n, flag_z, flag_c, flag_v} = flags;

    // Opcode decode of the registered ID slot; a bubble decodes as nothing.
    always_comb begin
        is_uncond = valid_ID && ((instr_ID[31:26] == 6'b000101) ||
                                 (instr_ID[31:26] == 6'b100101));
        is_cbz    = valid_ID && (instr_ID[31:24] == 8'b1011_0100);
        is_bcond  = valid_ID && (instr_ID[31:24] == 8'b0101_0100);
        is_br     = valid_ID && (instr_ID[31:21] == 11'b110_1011_0000);
    end

    // Condition-code evaluation for B.cond; code 1111 behaves as always.
    always_comb begin
        cond_true = 1'b0;
        case (instr_ID[3:0])
            4'h0:    cond_true = flag_z;
            4'h1:    cond_true = !flag_z;
            4'h2:    cond_true = flag_c;
            4'h3:    cond_true = !flag_c;
            4'h4:    cond_true = flag_n;
            4'h5:    cond_true = !flag_n;
            4'h6:    cond_true = flag_v;
            4'h7:    cond_true = !flag_v;
            4'h8:    cond_true = flag_c && !flag_z;
            4'h9:    cond_true = !flag_c || flag_z;
            4'hA:    cond_true = (flag_n == flag_v);
            4'hB:    cond_true = (flag_n != flag_v);
            4'hC:    cond_true = !flag_z && (flag_n == flag_v);
            4'hD:    cond_true = flag_z || (flag_n != flag_v);
            default: cond_true = 1'b1;
        endcase
    end

    // Next-state and next-PC control: reset, then stall, then flag wait, then resolve.
    always_comb begin
        state_next  = state;
        br_sel      = SEL_SEQ;
        UncondBr    = 1'b0;
        pc_hold     = 1'b0;
        hold_ifid   = 1'b0;
        squash_ifid = 1'b0;
        resolved    = 1'b0;
        if (reset) begin
            state_next = RUN;
        end else if (stall_in) begin
            pc_hold   = 1'b1;
            hold_ifid = 1'b1;
        end else if (is_bcond && !flags_valid) begin
            pc_hold    = 1'b1;
            hold_ifid  = 1'b1;
            state_next = WAIT_FLAGS;
        end else begin
            resolved = is_uncond || is_cbz || is_bcond || is_br;
            if (is_uncond) begin
                br_sel   = SEL_REL;
                UncondBr = 1'b1;
            end else if ((is_cbz && zero_reg) || (is_bcond && cond_true)) begin
                br_sel = SEL_REL;
            end else if (is_br) begin
                br_sel = SEL_REG;
            end
            if (br_sel != SEL_SEQ) begin
                squash_ifid = 1'b1;
                state_next  = SQUASH;
            end else begin
                state_next = RUN;
            end
        end
        BrTaken = br_sel;
    end

    // State register and IF/ID pipeline register; a taken branch loads a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            valid_ID   <= 1'b0;
            instr_ID   <= NOP_WORD;
            PCaddr_Reg <= 64'd0;
        end else begin
            state <= state_next;
            if (squash_ifid) begin
                valid_ID   <= 1'b0;
                instr_ID   <= NOP_WORD;
                PCaddr_Reg <= PCaddr_IF;
            end else if (!hold_ifid) begin
                valid_ID   <= 1'b1;
                instr_ID   <= instruction;
                PCaddr_Reg <= PCaddr_IF;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Branch statistics, counted on the edge where the branch leaves ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            br_count       <= 32'd0;
            br_taken_count <= 32'd0;
        end else if (resolved) begin
            br_count <= br_count + 32'd1;
            if (br_sel != SEL_SEQ) begin
                br_taken_count <= br_taken_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: reset, unconditional/compare/conditional
// branches, register branch under stall, flag wait, and mid-wait reset.
module tb_branch_resolve;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] I_B8   = 32'h1400_0002;
    localparam logic [31:0] I_BL   = 32'h9400_0001;
    localparam logic [31:0] I_CBZ  = 32'hB400_0061;
    localparam logic [31:0] I_BEQ  = 32'h5400_00A0;
    localparam logic [31:0] I_BR   = 32'hD61F_03C0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [63:0] PCaddr_IF;
    logic        stall_in;
    logic [3:0]  flags;
    logic        flags_valid;
    logic        zero_reg;
    logic [31:0] instr_ID;
    logic        valid_ID;
    logic [63:0] PCaddr_Reg;
    logic [1:0]  BrTaken;
    logic        UncondBr;
    logic [18:0] CondAddr19;
    logic [25:0] BrAddr26;
    logic        pc_hold;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_count;
    logic [31:0] br_taken_count;
`endif

    int vectors = 0;
    int errors  = 0;

    branch_resolve #(.NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .PCaddr_IF(PCaddr_IF),
        .stall_in(stall_in), .flags(flags), .flags_valid(flags_valid), .zero_reg(zero_reg),
        .instr_ID(instr_ID), .valid_ID(valid_ID), .PCaddr_Reg(PCaddr_Reg),
        .BrTaken(BrTaken), .UncondBr(UncondBr), .CondAddr19(CondAddr19),
        .BrAddr26(BrAddr26), .pc_hold(pc_hold)
`ifdef BRANCH_STATS_EN
        , .br_count(br_count), .br_taken_count(br_taken_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [63:0] pc);
        instruction = ins;
        PCaddr_IF   = pc;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall_in = 1'b0; flags = 4'h0; flags_valid = 1'b1; zero_reg = 1'b0;
        fetch(I_B8, 64'h0);
        tick(); tick();
        vectors++;
        if (valid_ID !== 1'b0 || BrTaken !== 2'b00 || pc_hold !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b br=%b hold=%b, want 0 00 0", valid_ID, BrTaken, pc_hold);
        end
        vectors++;
        if (instr_ID !== NOP || PCaddr_Reg !== 64'd0) begin
            errors++;
            $display("FAIL reset_regs: instr=%h pc=%h, want %h 0", instr_ID, PCaddr_Reg, NOP);
        end
        reset = 1'b0;
        fetch(32'h9100_0421, 64'h100);
        tick();
        vectors++;
        if (valid_ID !== 1'b1 || instr_ID !== 32'h9100_0421 || PCaddr_Reg !== 64'h100) begin
            errors++;
            $display("FAIL first_fetch: valid=%b instr=%h pc=%h, want 1 91000421 100", valid_ID, instr_ID, PCaddr_Reg);
        end
    endtask

    task automatic test_b();
        fetch(I_B8, 64'h40);
        tick();
        fetch(32'h9100_0001, 64'h44);
        #1;
        vectors++;
        if (BrTaken !== 2'b01 || UncondBr !== 1'b1 || PCaddr_Reg !== 64'h40 ||
            BrAddr26 !== 26'd2 || pc_hold !== 1'b0) begin
            errors++;
            $display("FAIL b_resolve: br=%b unc=%b pc=%h off=%h hold=%b, want 01 1 40 2 0",
                     BrTaken, UncondBr, PCaddr_Reg, BrAddr26, pc_hold);
        end
        tick();
        fetch(32'h9100_0002, 64'h48);
        #1;
        vectors++;
        if (valid_ID !== 1'b0 || instr_ID !== NOP || BrTaken !== 2'b00) begin
            errors++;
            $display("FAIL b_bubble: valid=%b instr=%h br=%b, want 0 %h 00", valid_ID, instr_ID, BrTaken, NOP);
        end
        tick();
        vectors++;
        if (valid_ID !== 1'b1 || instr_ID !== 32'h9100_0002 || PCaddr_Reg !== 64'h48) begin
            errors++;
            $display("FAIL b_target: valid=%b instr=%h pc=%h, want 1 91000002 48", valid_ID, instr_ID, PCaddr_Reg);
        end
    endtask

    task automatic test_cbz();
        zero_reg = 1'b0;
        fetch(I_CBZ, 64'h80);
        tick();
        fetch(32'h9100_0003, 64'h84);
        #1;
        vectors++;
        if (BrTaken !== 2'b00 || pc_hold !== 1'b0) begin
            errors++;
            $display("FAIL cbz_nt: br=%b hold=%b, want 00 0", BrTaken, pc_hold);
        end
        tick();
        vectors++;
        if (valid_ID !== 1'b1 || instr_ID !== 32'h9100_0003) begin
            errors++;
            $display("FAIL cbz_nt_next: valid=%b instr=%h, want 1 91000003", valid_ID, instr_ID);
        end
        fetch(I_CBZ, 64'h88);
        tick();
        zero_reg = 1'b1;
        fetch(32'h9100_0004, 64'h8C);
        #1;
        vectors++;
        if (BrTaken !== 2'b01 || UncondBr !== 1'b0 || CondAddr19 !== 19'd3) begin
            errors++;
            $display("FAIL cbz_taken: br=%b unc=%b off=%h, want 01 0 3", BrTaken, UncondBr, CondAddr19);
        end
        tick();
        zero_reg = 1'b0;
        fetch(32'h9100_0005, 64'h94);
        #1;
        vectors++;
        if (valid_ID !== 1'b0) begin
            errors++;
            $display("FAIL cbz_bubble: valid=%b, want 0", valid_ID);
        end
        tick();
        vectors++;
        if (valid_ID !== 1'b1 || instr_ID !== 32'h9100_0005) begin
            errors++;
            $display("FAIL cbz_target: valid=%b instr=%h, want 1 91000005", valid_ID, instr_ID);
        end
    endtask

    task automatic test_bcond_wait();
        flags_valid = 1'b1; flags = 4'h0;
        fetch(I_BEQ, 64'hC0);
        tick();
        flags_valid = 1'b0;
        fetch(32'h9100_0006, 64'hC4);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (pc_hold !== 1'b1 || BrTaken !== 2'b00 || instr_ID !== I_BEQ) begin
                errors++;
                $display("FAIL bcond_wait%0d: hold=%b br=%b instr=%h, want 1 00 %h", i, pc_hold, BrTaken, instr_ID, I_BEQ);
            end
            tick();
        end
        flags_valid = 1'b1;
        flags = 4'b0100;
        #1;
        vectors++;
        if (BrTaken !== 2'b01 || UncondBr !== 1'b0 || pc_hold !== 1'b0 || CondAddr19 !== 19'd5) begin
            errors++;
            $display("FAIL bcond_resolve: br=%b unc=%b hold=%b off=%h, want 01 0 0 5", BrTaken, UncondBr, pc_hold, CondAddr19);
        end
        tick();
        fetch(32'h9100_0007, 64'hE0);
        #1;
        vectors++;
        if (valid_ID !== 1'b0) begin
            errors++;
            $display("FAIL bcond_bubble: valid=%b, want 0", valid_ID);
        end
        tick();
        vectors++;
        if (valid_ID !== 1'b1 || instr_ID !== 32'h9100_0007) begin
            errors++;
            $display("FAIL bcond_target: valid=%b instr=%h, want 1 91000007", valid_ID, instr_ID);
        end
    endtask

    task automatic test_cond_codes();
        logic [3:0] cc [12];
        logic [3:0] fl [12];
        logic       ex [12];
        cc[0]  = 4'h0; fl[0]  = 4'b0100; ex[0]  = 1'b1;
        cc[1]  = 4'h1; fl[1]  = 4'b0100; ex[1]  = 1'b0;
        cc[2]  = 4'hA; fl[2]  = 4'b1001; ex[2]  = 1'b1;
        cc[3]  = 4'hB; fl[3]  = 4'b1000; ex[3]  = 1'b1;
        cc[4]  = 4'hC; fl[4]  = 4'b0000; ex[4]  = 1'b1;
        cc[5]  = 4'hD; fl[5]  = 4'b0000; ex[5]  = 1'b0;
        cc[6]  = 4'h8; fl[6]  = 4'b0010; ex[6]  = 1'b1;
        cc[7]  = 4'h9; fl[7]  = 4'b0010; ex[7]  = 1'b0;
        cc[8]  = 4'h4; fl[8]  = 4'b0000; ex[8]  = 1'b0;
        cc[9]  = 4'h6; fl[9]  = 4'b0001; ex[9]  = 1'b1;
        cc[10] = 4'h3; fl[10] = 4'b0010; ex[10] = 1'b0;
        cc[11] = 4'hE; fl[11] = 4'b0000; ex[11] = 1'b1;
        flags_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            fetch({28'h5400_002, cc[i]}, 64'h300);
            tick();
            flags = fl[i];
            fetch(32'h9100_0000, 64'h304);
            #1;
            vectors++;
            if (BrTaken !== (ex[i] ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL cond_%h: br=%b, want taken=%b", cc[i], BrTaken, ex[i]);
            end
            tick(); tick();
        end
    endtask

    task automatic test_br_stall();
        flags = 4'h0;
        fetch(I_BR, 64'h100);
        tick();
        stall_in = 1'b1;
        fetch(32'h9100_0008, 64'h104);
        #1;
        vectors++;
        if (BrTaken !== 2'b00 || pc_hold !== 1'b1 || instr_ID !== I_BR) begin
            errors++;
            $display("FAIL br_stall0: br=%b hold=%b instr=%h, want 00 1 %h", BrTaken, pc_hold, instr_ID, I_BR);
        end
        tick();
        vectors++;
        if (BrTaken !== 2'b00 || instr_ID !== I_BR || valid_ID !== 1'b1) begin
            errors++;
            $display("FAIL br_stall1: br=%b instr=%h valid=%b, want 00 %h 1", BrTaken, instr_ID, valid_ID, I_BR);
        end
        tick();
        stall_in = 1'b0;
        #1;
        vectors++;
        if (BrTaken !== 2'b10 || pc_hold !== 1'b0 || instr_ID !== I_BR) begin
            errors++;
            $display("FAIL br_release: br=%b hold=%b instr=%h, want 10 0 %h", BrTaken, pc_hold, instr_ID, I_BR);
        end
        tick();
        vectors++;
        if (valid_ID !== 1'b0) begin
            errors++;
            $display("FAIL br_bubble: valid=%b, want 0", valid_ID);
        end
        fetch(32'h9100_0009, 64'h400);
        tick();
    endtask

    task automatic test_back_to_back();
        fetch(I_B8, 64'h200);
        tick();
        fetch(I_BL, 64'h204);
        #1;
        vectors++;
        if (BrTaken !== 2'b01) begin
            errors++;
            $display("FAIL b2b_first: br=%b, want 01", BrTaken);
        end
        tick();
        fetch(I_BL, 64'h208);
        #1;
        vectors++;
        if (valid_ID !== 1'b0 || BrTaken !== 2'b00) begin
            errors++;
            $display("FAIL b2b_squashed: valid=%b br=%b, want 0 00", valid_ID, BrTaken);
        end
        tick();
        fetch(32'h9100_000A, 64'h20C);
        #1;
        vectors++;
        if (BrTaken !== 2'b01 || UncondBr !== 1'b1 || PCaddr_Reg !== 64'h208) begin
            errors++;
            $display("FAIL b2b_target_bl: br=%b unc=%b pc=%h, want 01 1 208", BrTaken, UncondBr, PCaddr_Reg);
        end
        tick();
        fetch(32'h9100_000B, 64'h600);
        tick();
    endtask

    task automatic test_reset_mid_wait();
        flags_valid = 1'b1;
        fetch(I_BEQ, 64'h500);
        tick();
        flags_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        #1;
        vectors++;
        if (valid_ID !== 1'b0 || pc_hold !== 1'b0 || BrTaken !== 2'b00) begin
            errors++;
            $display("FAIL reset_wait: valid=%b hold=%b br=%b, want 0 0 00", valid_ID, pc_hold, BrTaken);
        end
        reset = 1'b0;
        fetch(32'h9100_000C, 64'h0);
        tick();
        vectors++;
        if (valid_ID !== 1'b1 || instr_ID !== 32'h9100_000C) begin
            errors++;
            $display("FAIL reset_wait_resume: valid=%b instr=%h, want 1 9100000c", valid_ID, instr_ID);
        end
        flags_valid = 1'b1;
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        fetch(32'h9100_0000, 64'h0);
        tick();
        reset = 1'b0;
        flags_valid = 1'b1; zero_reg = 1'b0; flags = 4'b0100;
        fetch(I_B8, 64'h10);  tick(); fetch(32'h9100_0000, 64'h14); tick(); tick();
        fetch(I_CBZ, 64'h20); tick(); fetch(32'h9100_0000, 64'h24); tick(); tick();
        fetch(I_BR, 64'h30);  tick(); fetch(32'h9100_0000, 64'h34); tick(); tick();
        fetch(I_BEQ, 64'h40); tick(); fetch(32'h9100_0000, 64'h44); tick(); tick();
        vectors++;
        if (br_count !== 32'd4 || br_taken_count !== 32'd3) begin
            errors++;
            $display("FAIL stats: br=%0d taken=%0d, want 4 3", br_count, br_taken_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_b();
        test_cbz();
        test_bcond_wait();
        test_cond_codes();
        test_br_stall();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
